mult18x18: RTL and testbench
============================

Name: mult18x18

Overview:
- Signed 18x18 -> 36-bit two's-complement multiplier with a configurable register pipeline.
- Serves as the hard-multiplier core behind the Q17 fractional multiply wrapper used by the demodulator: oscillator x signal mixers, and IF squaring to baseband.
- Soft implementation, radix-4 Booth. Multiplication uses no `*` operator, so the block maps identically on any fabric.

Parameters:
LATENCY, 2, number of clock cycles from input sample to P/VALID_OUT. Legal range 0..3. At 0 the block is purely combinational and CLK/RST/CE are ignored.

Ports:
CLK  input  1  single clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
CE  input  1  clock enable; when low all pipeline state holds
VALID_IN  input  1  qualifies A/B in the current cycle
A  input  18  signed multiplicand, two's complement
B  input  18  signed multiplier, two's complement
P  output  36  signed product A*B, two's complement, full precision
VALID_OUT  output  1  VALID_IN delayed by LATENCY enabled cycles

Behaviour:
- Arithmetic: P equals the exact mathematical product of signed A and B. No rounding, no truncation, no saturation.
- 36 bits always suffice. Extremes:
  - (-131072)^2 = 0x4_0000_0000
  - (-131072)*131071 = 0xC_0002_0000
- Required structure: radix-4 Booth recoding of B into 9 digits in {-2,-1,0,+1,+2}, using B sign-extended with an appended 0 LSB.
  - Each digit selects 0, ±A or ±2A, sign-extended to 36 bits and shifted by 2*i.
  - The 9 partial products are summed in a tree (carry-save or adders); sum is modulo 2^36.
- Pipeline placement by LATENCY:
  - LATENCY=0: no registers.
  - LATENCY=1: output register only.
  - LATENCY=2: input register (A, B, VALID_IN) plus output register.
  - LATENCY=3: input register, a register after the partial-product tree's first level (4-5 partial sums), and an output register.
- Reset (LATENCY>=1):
  - On any rising edge with RST=1, every pipeline register clears to 0: P=0, VALID_OUT=0, all internal stages zero.
  - RST has priority over CE.
  - Reset mid-stream discards all in-flight products; no stale product may emerge after RST deasserts.
- Clock enable:
  - CE=0 freezes every stage, including VALID tracking. P and VALID_OUT hold their values.
  - Latency is counted in CE=1 cycles.
- Data registers load every enabled cycle regardless of VALID_IN. VALID is pure side-band. P for an invalid slot is the product of whatever A/B were present.
- Back-to-back: one new product accepted per enabled cycle, full throughput, no bubbles.
- Simultaneous events: with RST=1 and CE=1 on the same edge, reset wins.
- Inputs held constant: P settles to A*B after LATENCY enabled edges and stays stable.
- No X propagation from reset state: P is defined (0) from the first reset edge.

Test Plan:
- LATENCY=2; RST for 2 cycles, then A=3, B=5, VALID_IN=1 for 1 cycle -> VALID_OUT=1 exactly 2 enabled cycles later with P=0x0_0000_000F. Both are 0 before that.
- Sign corners, each held:
  - A=-1, B=-1 -> P=1
  - A=-131072, B=-131072 -> P=0x4_0000_0000
  - A=-131072, B=131071 -> P=0xC_0002_0000
  - A=131071, B=131071 -> P=0x3_FFFC_0001
  - A=0, B=-131072 -> P=0
- Streaming: random A/B every cycle with CE=1 -> P at cycle n+LATENCY matches the reference product of cycle n. Run 10k vectors for each LATENCY 0..3.
- CE gating: stream 3 valid products and drop CE for 4 cycles mid-flight -> P/VALID_OUT frozen during the gap. Results emerge in order, none lost or duplicated.
- Reset mid-operation: issue 2 valid products, then assert RST on the next edge -> P=0 and VALID_OUT=0 from that edge. No VALID_OUT pulse appears after RST deasserts until new VALID_IN.
- Q17 wrapper check: A=0x1D000 (118784), B=0x10000 (65536) -> P=0x1_D000_0000. P>>>17 = 0x0E800.

Source files
------------

// File: rtl/mult18x18.sv
// Signed 18x18 -> 36-bit radix-4 Booth multiplier with a 0..3 stage register pipeline.
// Stages: optional input register, optional first-level tree register, optional output register.
module mult18x18 #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        VALID_IN,
    input  logic [17:0] A,
    input  logic [17:0] B,
    output logic [35:0] P,
    output logic        VALID_OUT
);
    localparam int unsigned NumPp  = 9;
    localparam int unsigned NumSum = 5;

    logic [17:0] a_s0;
    logic [17:0] b_s0;
    logic        v_s0;

    generate
        if (LATENCY >= 2) begin : g_in_reg
            logic [17:0] a_q, a_d;
            logic [17:0] b_q, b_d;
            logic        v_q, v_d;

            always_comb begin
                a_d = a_q;
                b_d = b_q;
                v_d = v_q;
                if (CE) begin
                    a_d = A;
                    b_d = B;
                    v_d = VALID_IN;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    a_q <= '0;
                    b_q <= '0;
                    v_q <= 1'b0;
                end else begin
                    a_q <= a_d;
                    b_q <= b_d;
                    v_q <= v_d;
                end
            end

            assign a_s0 = a_q;
            assign b_s0 = b_q;
            assign v_s0 = v_q;
        end else begin : g_in_bypass
            assign a_s0 = A;
            assign b_s0 = B;
            assign v_s0 = VALID_IN;
        end
    endgenerate

    // Booth digit i is taken from bits [2i+2:2i] of B with a zero appended below the LSB.
    logic [18:0] b_ext;
    logic [35:0] a_pos;
    logic [35:0] a_neg;
    logic [35:0] pp [NumPp];

    assign b_ext = {b_s0, 1'b0};
    assign a_pos = {{18{a_s0[17]}}, a_s0};
    assign a_neg = ~a_pos + 36'd1;

    always_comb begin
        for (int i = 0; i < NumPp; i++) begin
            unique case (b_ext[2*i +: 3])
                3'b001, 3'b010: pp[i] = a_pos << (2 * i);
                3'b011:         pp[i] = a_pos << (2 * i + 1);
                3'b100:         pp[i] = a_neg << (2 * i + 1);
                3'b101, 3'b110: pp[i] = a_neg << (2 * i);
                default:        pp[i] = '0;
            endcase
        end
    end

    logic [35:0] sum1 [NumSum];

    always_comb begin
        for (int j = 0; j < NumSum - 1; j++) begin
            sum1[j] = pp[2*j] + pp[2*j+1];
        end
        sum1[NumSum-1] = pp[NumPp-1];
    end

    logic [35:0] sum1_s [NumSum];
    logic        v_s1;

    generate
        if (LATENCY >= 3) begin : g_mid_reg
            logic [35:0] sum_q [NumSum];
            logic [35:0] sum_d [NumSum];
            logic        v_q, v_d;

            always_comb begin
                sum_d = sum_q;
                v_d   = v_q;
                if (CE) begin
                    sum_d = sum1;
                    v_d   = v_s0;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    sum_q <= '{default: '0};
                    v_q   <= 1'b0;
                end else begin
                    sum_q <= sum_d;
                    v_q   <= v_d;
                end
            end

            assign sum1_s = sum_q;
            assign v_s1   = v_q;
        end else begin : g_mid_bypass
            assign sum1_s = sum1;
            assign v_s1   = v_s0;
        end
    endgenerate

    logic [35:0] prod;

    always_comb begin
        prod = '0;
        for (int k = 0; k < NumSum; k++) begin
            prod = prod + sum1_s[k];
        end
    end

    generate
        if (LATENCY >= 1) begin : g_out_reg
            logic [35:0] p_q, p_d;
            logic        v_q, v_d;

            always_comb begin
                p_d = p_q;
                v_d = v_q;
                if (CE) begin
                    p_d = prod;
                    v_d = v_s1;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    p_q <= '0;
                    v_q <= 1'b0;
                end else begin
                    p_q <= p_d;
                    v_q <= v_d;
                end
            end

            assign P         = p_q;
            assign VALID_OUT = v_q;
        end else begin : g_out_bypass
            assign P         = prod;
            assign VALID_OUT = v_s1;
        end
    endgenerate

endmodule

// File: tb/tb_mult18x18.sv
// Bench for mult18x18: four instances (LATENCY 0..3) share stimulus; directed vectors,
// CE-gap and mid-stream reset sequences, then a random stream checked against a delay-line model.
module tb_mult18x18;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ce;
    logic        vin;
    logic [17:0] a;
    logic [17:0] b;
    logic [35:0] p_l [4];
    logic        v_l [4];

    mult18x18 #(.LATENCY(0)) u_l0 (.CLK(clk), .RST(rst), .CE(ce), .VALID_IN(vin), .A(a), .B(b),
                                   .P(p_l[0]), .VALID_OUT(v_l[0]));
    mult18x18 #(.LATENCY(1)) u_l1 (.CLK(clk), .RST(rst), .CE(ce), .VALID_IN(vin), .A(a), .B(b),
                                   .P(p_l[1]), .VALID_OUT(v_l[1]));
    mult18x18 #(.LATENCY(2)) u_l2 (.CLK(clk), .RST(rst), .CE(ce), .VALID_IN(vin), .A(a), .B(b),
                                   .P(p_l[2]), .VALID_OUT(v_l[2]));
    mult18x18 #(.LATENCY(3)) u_l3 (.CLK(clk), .RST(rst), .CE(ce), .VALID_IN(vin), .A(a), .B(b),
                                   .P(p_l[3]), .VALID_OUT(v_l[3]));

    int total = 0;
    int bad   = 0;

    function automatic logic [35:0] ref_prod(logic [17:0] x, logic [17:0] y);
        logic signed [35:0] xs;
        logic signed [35:0] ys;
        xs = $signed(x);
        ys = $signed(y);
        return 36'(xs * ys);
    endfunction

    task automatic chk36(string name, logic [35:0] act, logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Reference delay line: entry k holds the product loaded k+1 enabled edges ago.
    logic [35:0] hist_p [3];
    logic        hist_v [3];
    bit          model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                hist_p[k] <= '0;
                hist_v[k] <= 1'b0;
            end
        end else if (ce) begin
            hist_p[0] <= ref_prod(a, b);
            hist_v[0] <= vin;
            for (int k = 1; k < 3; k++) begin
                hist_p[k] <= hist_p[k-1];
                hist_v[k] <= hist_v[k-1];
            end
        end
    end

    task automatic check_model();
        if (model_on) begin
            chk36("model_l0_p", p_l[0], ref_prod(a, b));
            chk1("model_l0_v", v_l[0], vin);
            for (int k = 1; k < 4; k++) begin
                chk36($sformatf("model_l%0d_p", k), p_l[k], hist_p[k-1]);
                chk1($sformatf("model_l%0d_v", k), v_l[k], hist_v[k-1]);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [17:0] a;
        logic [17:0] b;
        logic [35:0] p;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{a: 18'h3FFFF, b: 18'h3FFFF, p: 36'h0_0000_0001};
        tbl[1] = '{a: 18'h20000, b: 18'h20000, p: 36'h4_0000_0000};
        tbl[2] = '{a: 18'h20000, b: 18'h1FFFF, p: 36'hC_0002_0000};
        tbl[3] = '{a: 18'h1FFFF, b: 18'h1FFFF, p: 36'h3_FFFC_0001};
        tbl[4] = '{a: 18'h00000, b: 18'h20000, p: 36'h0_0000_0000};
        tbl[5] = '{a: 18'h1D000, b: 18'h10000, p: 36'h1_D000_0000};
        tbl[6] = '{a: 18'h3FFFD, b: 18'h00007, p: 36'hF_FFFF_FFEB};
        tbl[7] = '{a: 18'h03039, b: 18'h3FFFE, p: 36'hF_FFFF_9F8E};
        tbl[8] = '{a: 18'h1FFFF, b: 18'h3FFFF, p: 36'hF_FFFE_0001};
        tbl[9] = '{a: 18'h00003, b: 18'h00005, p: 36'h0_0000_000F};

        rst = 1'b1;
        ce  = 1'b1;
        vin = 1'b0;
        a   = '0;
        b   = '0;
        tick();
        tick();
        model_on = 1'b1;
        for (int k = 1; k < 4; k++) begin
            chk36($sformatf("reset_l%0d_p", k), p_l[k], 36'h0);
            chk1($sformatf("reset_l%0d_v", k), v_l[k], 1'b0);
        end

        // First transaction: 3*5 appears exactly two edges later on the LATENCY=2 instance.
        rst = 1'b0;
        a   = 18'd3;
        b   = 18'd5;
        vin = 1'b1;
        tick();
        chk36("first_e1_p", p_l[2], 36'h0);
        chk1("first_e1_v", v_l[2], 1'b0);
        a   = '0;
        b   = '0;
        vin = 1'b0;
        tick();
        chk36("first_e2_p", p_l[2], 36'hF);
        chk1("first_e2_v", v_l[2], 1'b1);
        tick();
        chk1("first_e3_v", v_l[2], 1'b0);

        for (int i = 0; i < 10; i++) begin
            a   = tbl[i].a;
            b   = tbl[i].b;
            vin = 1'b1;
            repeat (4) tick();
            for (int k = 0; k < 4; k++) begin
                chk36($sformatf("vec%0d_l%0d_p", i, k), p_l[k], tbl[i].p);
            end
            chk1($sformatf("vec%0d_v", i), v_l[2], 1'b1);
        end

        // CE gap with three products in flight.
        a = 18'd2; b = 18'd3; vin = 1'b1;
        tick();
        a = 18'd4; b = 18'd5;
        tick();
        a = 18'd6; b = 18'd7;
        tick();
        chk36("gap_pre_l2_p", p_l[2], 36'd20);
        ce = 1'b0; a = 18'd9; b = 18'd9; vin = 1'b0;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk36($sformatf("gap%0d_l1_p", g), p_l[1], 36'd42);
            chk36($sformatf("gap%0d_l2_p", g), p_l[2], 36'd20);
            chk36($sformatf("gap%0d_l3_p", g), p_l[3], 36'd6);
            chk1($sformatf("gap%0d_l2_v", g), v_l[2], 1'b1);
        end
        ce = 1'b1; a = '0; b = '0;
        tick();
        chk36("gap_post1_l2_p", p_l[2], 36'd42);
        chk1("gap_post1_l2_v", v_l[2], 1'b1);
        chk36("gap_post1_l3_p", p_l[3], 36'd20);
        chk1("gap_post1_l1_v", v_l[1], 1'b0);
        tick();
        chk36("gap_post2_l2_p", p_l[2], 36'd0);
        chk1("gap_post2_l2_v", v_l[2], 1'b0);
        chk36("gap_post2_l3_p", p_l[3], 36'd42);
        chk1("gap_post2_l3_v", v_l[3], 1'b1);
        tick();
        chk1("gap_post3_l3_v", v_l[3], 1'b0);

        // Reset while two products are in flight.
        a = 18'd5; b = 18'd5; vin = 1'b1;
        tick();
        a = 18'd6; b = 18'd6;
        tick();
        rst = 1'b1; a = 18'd7; b = 18'd7;
        tick();
        for (int k = 1; k < 4; k++) begin
            chk36($sformatf("midrst_l%0d_p", k), p_l[k], 36'h0);
            chk1($sformatf("midrst_l%0d_v", k), v_l[k], 1'b0);
        end
        rst = 1'b0; a = 18'd8; b = 18'd8; vin = 1'b0;
        for (int r = 0; r < 4; r++) begin
            tick();
            for (int k = 1; k < 4; k++) begin
                chk1($sformatf("postrst%0d_l%0d_v", r, k), v_l[k], 1'b0);
            end
        end

        // Random stream with occasional CE drops.
        for (int n = 0; n < 10000; n++) begin
            a   = 18'($urandom);
            b   = 18'($urandom);
            vin = 1'($urandom);
            ce  = ($urandom_range(7) != 0);
            tick();
        end
        ce = 1'b1;
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
